// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared helpers for the parametrised synchronous FIFO
package sync_fifo_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Depth must be a power of two so the pointer MSB acts as a wrap bit.
    function automatic bit fifo_params_ok(input int data_w, input int depth,
                                          input int af_level, input int ae_level);
        return (data_w >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0) &&
               (af_level >= 1) && (af_level <= depth) &&
               (ae_level >= 0) && (ae_level <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_W register array, one write port, one registered read port
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is deliberately left unreset; only the output register clears.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock FIFO with occupancy, threshold flags, flush and sticky errors
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr,
    input  logic [DATA_W-1:0]       datain,
    input  logic                    rd,
    input  logic                    flush,
    output logic [DATA_W-1:0]       dataout,
    output logic                    rd_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [clog2(DEPTH):0]   count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int          AW      = clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] AF_L    = AF_LEVEL[AW:0];
    localparam logic [AW:0] AE_L    = AE_LEVEL[AW:0];

    generate
        if (!fifo_params_ok(DATA_W, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
            $fatal(1, "sync_fifo_param: illegal DATA_W/DEPTH/AF_LEVEL/AE_LEVEL");
        end
    endgenerate

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        wr_acc;
    logic        rd_acc;

    // Flags come only from registered pointers, never from wr/rd.
    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count        = wr_ptr - rd_ptr;
    assign almost_full  = (count >= AF_L);
    assign almost_empty = (count <= AE_L);

    assign wr_acc = wr & ~full & ~flush;
    assign rd_acc = rd & ~empty & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            rd_valid <= rd_acc;
            if (wr && full) begin
                overflow <= 1'b1;
            end
            if (rd && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk    (clk),
        .rst    (rst),
        .we     (wr_acc),
        .waddr  (wr_ptr[AW-1:0]),
        .wdata  (datain),
        .re     (rd_acc),
        .raddr  (rd_ptr[AW-1:0]),
        .rdata  (dataout)
    );

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - randomized and directed bench for sync_fifo_param against a queue model
module tb_sync_fifo_param;

    localparam int DATA_W   = 8;
    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = 12;
    localparam int AE_LEVEL = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr;
    logic [DATA_W-1:0] datain;
    logic              rd;
    logic              flush;
    logic [DATA_W-1:0] dataout;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [4:0]        count;
    logic              overflow;
    logic              underflow;

    sync_fifo_param #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr           (wr),
        .datain       (datain),
        .rd           (rd),
        .flush        (flush),
        .dataout      (dataout),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] m_q[$];
    logic [DATA_W-1:0] m_dout;
    logic              m_rv;
    logic              m_ov;
    logic              m_un;
    int                n_checks = 0;
    int                n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        int sz;
        sz = m_q.size();
        check("count", 32'(count), 32'(sz));
        check("full", 32'(full), 32'(sz == DEPTH));
        check("empty", 32'(empty), 32'(sz == 0));
        check("almost_full", 32'(almost_full), 32'(sz >= AF_LEVEL));
        check("almost_empty", 32'(almost_empty), 32'(sz <= AE_LEVEL));
        check("rd_valid", 32'(rd_valid), 32'(m_rv));
        check("dataout", 32'(dataout), 32'(m_dout));
        check("overflow", 32'(overflow), 32'(m_ov));
        check("underflow", 32'(underflow), 32'(m_un));
    endtask

    // Drive one cycle of inputs, advance the model by the same cycle, compare.
    task automatic step(input logic w, input logic [DATA_W-1:0] d, input logic r,
                        input logic f, input logic rs);
        bit was_full;
        bit was_empty;
        wr = w; datain = d; rd = r; flush = f; rst = rs;
        @(posedge clk);
        #1;
        was_full  = (m_q.size() == DEPTH);
        was_empty = (m_q.size() == 0);
        if (rs) begin
            m_q.delete();
            m_dout = '0; m_rv = 1'b0; m_ov = 1'b0; m_un = 1'b0;
        end else if (f) begin
            m_q.delete();
            m_rv = 1'b0;
        end else begin
            if (w && was_full)  m_ov = 1'b1;
            if (r && was_empty) m_un = 1'b1;
            m_rv = 1'b0;
            if (r && !was_empty) begin
                m_dout = m_q.pop_front();
                m_rv   = 1'b1;
            end
            if (w && !was_full) m_q.push_back(d);
        end
        compare_all();
    endtask

    initial begin
        wr = 1'b0; datain = '0; rd = 1'b0; flush = 1'b0; rst = 1'b1;
        m_dout = '0; m_rv = 1'b0; m_ov = 1'b0; m_un = 1'b0;

        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_almost_empty", 32'(almost_empty), 32'd1);
        check("rst_dataout", 32'(dataout), 32'd0);

        for (int i = 1; i <= DEPTH; i++) begin
            step(1, DATA_W'(i), 0, 0, 0);
            if (i == AF_LEVEL) check("af_at_level", 32'(almost_full), 32'd1);
            if (i == AF_LEVEL - 1) check("af_below_level", 32'(almost_full), 32'd0);
        end
        check("fill_full", 32'(full), 32'd1);
        step(1, 8'hEE, 0, 0, 0);
        check("fill_overflow", 32'(overflow), 32'd1);
        check("fill_count_hold", 32'(count), 32'd16);

        for (int i = 1; i <= DEPTH; i++) begin
            step(0, 8'h00, 1, 0, 0);
            check("drain_order", 32'(dataout), 32'(i));
        end
        step(0, 8'h00, 1, 0, 0);
        check("drain_underflow", 32'(underflow), 32'd1);
        check("drain_dataout_hold", 32'(dataout), 32'h10);
        check("drain_rv_low", 32'(rd_valid), 32'd0);

        for (int i = 0; i < 5; i++) step(1, DATA_W'(8'h40 + i), 0, 0, 0);
        for (int i = 0; i < 40; i++) step(1, DATA_W'(8'h80 + i), 1, 0, 0);
        check("stream_count", 32'(count), 32'd5);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0, 0);

        step(0, 8'h00, 0, 0, 1);
        step(1, 8'h5A, 1, 0, 0);
        check("wr_rd_empty_count", 32'(count), 32'd1);
        check("wr_rd_empty_underflow", 32'(underflow), 32'd1);
        check("wr_rd_empty_rv", 32'(rd_valid), 32'd0);

        for (int i = 0; i < 8; i++) step(1, DATA_W'(8'hC0 + i), 0, 0, 0);
        step(1, 8'hFF, 0, 1, 0);
        check("flush_count", 32'(count), 32'd0);
        step(1, 8'h11, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        check("flush_discard", 32'(dataout), 32'h11);

        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) < 55), DATA_W'($urandom), ($urandom_range(0, 99) < 50),
                 ($urandom_range(0, 99) < 2), ($urandom_range(0, 199) < 1));
        end

        for (int i = 0; i < 6; i++) step(1, DATA_W'(8'h30 + i), 1, 0, 0);
        step(1, 8'h77, 1, 0, 1);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_dataout", 32'(dataout), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
